// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int FLAG_W = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier retiring one multiplier bit per clock.
// done is high during the final step; product_* carry that step's value.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   sum;

  // hi:lo is the partial product; lo doubles as the multiplier shift register.
  assign sum        = {1'b0, hi} + {1'b0, (lo[0] ? mcand : '0)};
  assign product_hi = sum[WIDTH:1];
  assign product_lo = {sum[0], lo[WIDTH-1:1]};
  assign done       = running && (count == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
    end else if (running) begin
      running <= !done;
      count   <= count + 1'b1;
    end
  end

  // NOTE: pure datapath registers are left without reset; they are always
  // loaded by start before running qualifies them.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand <= a;
      hi    <= '0;
      lo    <= b;
    end else if (running) begin
      hi <= product_hi;
      lo <= product_lo;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU core: single-cycle ops plus an iterative multiplier,
// valid/ready on both sides and an accumulator that can feed operand A.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              use_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  result_hi,
  output logic [FLAG_W-1:0] flags,
  output logic [WIDTH-1:0]  acc
);

  localparam int SW = $clog2(WIDTH);

  state_e           state;
  op_e              op_sel;
  logic             accept;
  logic [WIDTH-1:0] opa;
  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             mul_done;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic [WIDTH-1:0] res,
                                                   input logic [WIDTH-1:0] hi,
                                                   input logic c, input logic v);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_Z] = (res == '0) && (hi == '0);
    f[FLAG_N] = res[WIDTH-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign op_sel   = op_e'(op);
  assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign opa      = use_acc ? acc : a;
  assign shamt    = b[SW-1:0];

  // The extra bit on each shifter catches the last bit shifted out.
  assign sum_ext  = {1'b0, opa} + {1'b0, b};
  assign diff_ext = {1'b0, opa} - {1'b0, b};
  assign shl_ext  = {1'b0, opa} << shamt;
  assign shr_ext  = {opa, 1'b0} >> shamt;

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_sel)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (opa[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (opa[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND: alu_res = opa & b;
      OP_OR:  alu_res = opa | b;
      OP_XOR: alu_res = opa ^ b;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      default: ;
    endcase
  end

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start      (accept && (op_sel == OP_MUL)),
    .a          (opa),
    .b          (b),
    .done       (mul_done),
    .product_lo (prod_lo),
    .product_hi (prod_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      acc       <= '0;
    end else if (accept) begin
      if (op_sel == OP_MUL) begin
        state     <= ST_BUSY;
        out_valid <= 1'b0;
      end else begin
        state     <= ST_HOLD;
        out_valid <= 1'b1;
        result    <= alu_res;
        result_hi <= '0;
        flags     <= pack_flags(alu_res, '0, alu_c, alu_v);
        acc       <= alu_res;
      end
    end else begin
      case (state)
        ST_BUSY: begin
          if (mul_done) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            result    <= prod_lo;
            result_hi <= prod_hi;
            flags     <= pack_flags(prod_lo, prod_hi, prod_hi != '0, 1'b0);
            acc       <= prod_lo;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core at WIDTH=8: expected results are queued
// at acceptance and compared by a monitor when the result handshake fires.
module tb_alu_seq_core;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   flags;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         use_acc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;
  logic [W-1:0] acc;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  exp_t         mon_exp;
  logic [W-1:0] model_acc = '0;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic [W-1:0] accv,
                                 input logic ua);
    int   x, y, sx, sy, s, amt;
    logic c, v;
    exp_t e;
    x   = ua ? int'(accv) : int'(av);
    y   = int'(bv);
    sx  = (x > 127) ? x - 256 : x;
    sy  = (y > 127) ? y - 256 : y;
    amt = y % 8;
    c   = 1'b0;
    v   = 1'b0;
    e.hi = '0;
    case (o)
      3'd0: begin s = x + y; e.res = W'(s & 255); c = (s > 255); v = ((sx + sy) > 127) || ((sx + sy) < -128); end
      3'd1: begin s = x - y; e.res = W'(s & 255); c = (x < y);   v = ((sx - sy) > 127) || ((sx - sy) < -128); end
      3'd2: e.res = W'(x & y);
      3'd3: e.res = W'(x | y);
      3'd4: e.res = W'(x ^ y);
      3'd5: begin e.res = W'((x << amt) & 255); c = (amt != 0) && (((x >> (8 - amt)) & 1) == 1); end
      3'd6: begin e.res = W'(x >> amt); c = (amt != 0) && (((x >> (amt - 1)) & 1) == 1); end
      default: begin s = x * y; e.res = W'(s & 255); e.hi = W'(s >> 8); c = (e.hi != 0); end
    endcase
    e.flags = {v, e.res[W-1], c, (e.res == 0) && (e.hi == 0)};
    return e;
  endfunction

  // Result monitor: pops the scoreboard on every completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got result=%h hi=%h, required no output", result, result_hi);
      end else begin
        mon_exp = sb.pop_front();
        if ({result, result_hi, flags, acc} !== {mon_exp.res, mon_exp.hi, mon_exp.flags, mon_exp.res}) begin
          errors++;
          $display("FAIL scoreboard: got res=%h hi=%h flags=%b acc=%h, required res=%h hi=%h flags=%b acc=%h",
                   result, result_hi, flags, acc, mon_exp.res, mon_exp.hi, mon_exp.flags, mon_exp.res);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Presents one request and holds it until accepted; queues the expected result.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ua, input bit expect_res);
    bit   accepted;
    exp_t e;
    op       = o;
    a        = av;
    b        = bv;
    use_acc  = ua;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
      step();
      out_ready = 1'b1;
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after 40 cycles, required 1", in_ready);
    end else if (expect_res) begin
      e = model(o, av, bv, model_acc, ua);
      sb.push_back(e);
      model_acc = e.res;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; use_acc = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_handshake: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    checks++;
    if ({result, result_hi, flags, acc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h hi=%h flags=%b acc=%h, required all 0", result, result_hi, flags, acc);
    end
    step();
    rst = 1'b0;
    model_acc = '0;
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1;
    issue(3'd0, 8'h7F, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_valid, result, flags} !== {1'b1, 8'h80, 4'b1100}) begin
      errors++;
      $display("FAIL add_overflow: got valid=%b res=%h flags=%b, required 1 80 1100", out_valid, result, flags);
    end
    step();
    wait_drain();
  endtask

  task automatic test_sub_acc();
    out_ready = 1'b1;
    issue(3'd1, 8'h00, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({result, flags} !== {8'hFF, 4'b0110}) begin
      errors++;
      $display("FAIL sub_borrow: got res=%h flags=%b, required ff 0110", result, flags);
    end
    step();
    issue(3'd1, 8'h00, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if ({result, flags} !== {8'h00, 4'b0001}) begin
      errors++;
      $display("FAIL sub_acc_zero: got res=%h flags=%b, required 00 0001", result, flags);
    end
    step();
    wait_drain();
  endtask

  task automatic test_mul();
    int lat;
    out_ready = 1'b1;
    lat = 0;
    issue(3'd7, 8'hFF, 8'hFF, 1'b0, 1'b1);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL mul_busy_ready: cycle %0d in_ready=%b, required 0", n, in_ready);
      end
      step();
      in_valid = (n < 5);
      op = 3'd0;
      a  = 8'h11;
      b  = 8'h22;
    end
    in_valid = 1'b0;
    checks++;
    if (lat != 9) begin
      errors++;
      $display("FAIL mul_latency: got %0d cycles, required 9", lat);
    end
    checks++;
    if ({result_hi, result, flags} !== {8'hFE, 8'h01, 4'b0010}) begin
      errors++;
      $display("FAIL mul_ff_ff: got hi=%h res=%h flags=%b, required fe 01 0010", result_hi, result, flags);
    end
    step();
    wait_drain();
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_request_ignored: out_valid=%b, required 0", out_valid);
    end
    step();
  endtask

  task automatic test_hold_stall();
    out_ready = 1'b0;
    issue(3'd4, 8'h5A, 8'h0F, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, result, result_hi, flags} !== {2'b10, sb[0].res, sb[0].hi, sb[0].flags}) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d valid=%b ready=%b res=%h hi=%h flags=%b, required 1 0 %h %h %b",
                 n, out_valid, in_ready, result, result_hi, flags, sb[0].res, sb[0].hi, sb[0].flags);
      end
      step();
    end
    out_ready = 1'b1;
    issue(3'd0, 8'h00, 8'h10, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_valid, result} !== {1'b1, 8'h65}) begin
      errors++;
      $display("FAIL back_to_back: got valid=%b res=%h, required 1 65", out_valid, result);
    end
    step();
    wait_drain();
  endtask

  task automatic test_shifts();
    out_ready = 1'b1;
    issue(3'd5, 8'h81, 8'h09, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({result, flags} !== {8'h02, 4'b0010}) begin
      errors++;
      $display("FAIL shl_mod: got res=%h flags=%b, required 02 0010", result, flags);
    end
    step();
    issue(3'd6, 8'h81, 8'h08, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({result, flags} !== {8'h81, 4'b0100}) begin
      errors++;
      $display("FAIL shr_zero_amount: got res=%h flags=%b, required 81 0100", result, flags);
    end
    step();
    issue(3'd6, 8'h81, 8'h01, 1'b0, 1'b1);
    wait_drain();
  endtask

  task automatic test_mid_mul_reset();
    out_ready = 1'b1;
    issue(3'd7, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) step();
    rst      = 1'b1;
    in_valid = 1'b1;
    op       = 3'd0;
    step();
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, acc, result, flags} !== {2'b01, 8'h00, 8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL mid_mul_reset: got valid=%b ready=%b acc=%h res=%h flags=%b, required 0 1 00 00 0000",
               out_valid, in_ready, acc, result, flags);
    end
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    model_acc = '0;
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 15; n++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL abort_no_result: out_valid seen after reset, required none");
      end
    end
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      out_ready = 1'($urandom_range(0, 1));
      issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_acc();
    test_mul();
    test_hold_stall();
    test_shifts();
    test_mid_mul_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
